// File: rtl/image_ram_arbiter_if.sv
// Bus bundle between the image RAM arbiter, its three requesters and the RAM.
// The slave side is the arbiter; the master side is requesters plus RAM.
interface image_ram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;

   logic              eng_req;
   logic              eng_we;
   logic [ADDR_W-1:0] eng_addr;
   logic [DATA_W-1:0] eng_wdata;
   logic              eng_gnt;
   logic [DATA_W-1:0] eng_rdata;
   logic              eng_rvalid;

   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      input  disp_req, disp_addr,
      output disp_rdata, disp_rvalid,
      input  ld_req, ld_addr, ld_wdata,
      output ld_gnt,
      input  eng_req, eng_we, eng_addr, eng_wdata,
      output eng_gnt, eng_rdata, eng_rvalid,
      output ram_address, ram_data, ram_wren,
      input  ram_q
   );

   modport master (
      output disp_req, disp_addr,
      input  disp_rdata, disp_rvalid,
      output ld_req, ld_addr, ld_wdata,
      input  ld_gnt,
      output eng_req, eng_we, eng_addr, eng_wdata,
      input  eng_gnt, eng_rdata, eng_rvalid,
      input  ram_address, ram_data, ram_wren,
      output ram_q
   );
endinterface

// File: rtl/image_ram_arbiter.sv
// Image RAM arbiter: display has absolute priority, loader and engine
// share the remaining cycles round-robin; reads return via a tag pipeline.
module image_ram_arbiter #(
   parameter int          ADDR_W    = 16,
   parameter int          DATA_W    = 32,
   parameter int unsigned IMG_WORDS = 65536,
   parameter int          RAM_LAT   = 1
) (
   input logic          clk,
   input logic          reset,
   image_ram_arbiter_if.slave bus
);
   typedef enum logic {OWN_DISP, OWN_ENG} owner_e;
   typedef enum logic {RR_LD, RR_ENG} rr_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   oor;
   } tag_t;

   localparam logic [ADDR_W:0] LIMIT = IMG_WORDS[ADDR_W:0];

   function automatic logic is_oor(input logic [ADDR_W-1:0] a);
      return {1'b0, a} >= LIMIT;
   endfunction

   rr_e  rr_last;
   tag_t tag_q [RAM_LAT+1];
   tag_t tag_in;
   logic ld_win;
   logic eng_win;

   always_comb begin
      ld_win  = 1'b0;
      eng_win = 1'b0;
      if (!reset && !bus.disp_req) begin
         if (bus.ld_req && (!bus.eng_req || rr_last == RR_ENG))
            ld_win = 1'b1;
         else if (bus.eng_req)
            eng_win = 1'b1;
      end
   end

   assign bus.ld_gnt  = ld_win;
   assign bus.eng_gnt = eng_win;

   always_comb begin
      tag_in = '0;
      if (bus.disp_req) begin
         tag_in.valid = 1'b1;
         tag_in.owner = OWN_DISP;
         tag_in.oor   = is_oor(bus.disp_addr);
      end else if (eng_win && !bus.eng_we) begin
         tag_in.valid = 1'b1;
         tag_in.owner = OWN_ENG;
         tag_in.oor   = is_oor(bus.eng_addr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.ram_address <= '0;
         bus.ram_data    <= '0;
         bus.ram_wren    <= 1'b0;
         bus.disp_rdata  <= '0;
         bus.disp_rvalid <= 1'b0;
         bus.eng_rdata   <= '0;
         bus.eng_rvalid  <= 1'b0;
         rr_last         <= RR_ENG;
         for (int i = 0; i <= RAM_LAT; i++)
            tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i <= RAM_LAT; i++)
            tag_q[i] <= tag_q[i-1];

         // Output stage: ram_q now belongs to the oldest tag.
         bus.disp_rvalid <= 1'b0;
         bus.eng_rvalid  <= 1'b0;
         if (tag_q[RAM_LAT].valid) begin
            if (tag_q[RAM_LAT].owner == OWN_DISP) begin
               bus.disp_rvalid <= 1'b1;
               bus.disp_rdata  <= tag_q[RAM_LAT].oor ? '0 : bus.ram_q;
            end else begin
               bus.eng_rvalid <= 1'b1;
               bus.eng_rdata  <= tag_q[RAM_LAT].oor ? '0 : bus.ram_q;
            end
         end

         bus.ram_wren <= 1'b0;
         if (bus.disp_req) begin
            bus.ram_address <= bus.disp_addr;
         end else if (ld_win) begin
            bus.ram_address <= bus.ld_addr;
            bus.ram_data    <= bus.ld_wdata;
            bus.ram_wren    <= !is_oor(bus.ld_addr);
            rr_last         <= RR_LD;
         end else if (eng_win) begin
            bus.ram_address <= bus.eng_addr;
            bus.ram_data    <= bus.eng_wdata;
            bus.ram_wren    <= bus.eng_we && !is_oor(bus.eng_addr);
            rr_last         <= RR_ENG;
         end
      end
   end
endmodule

// File: tb/tb_image_ram_arbiter.sv
// Scoreboard bench for image_ram_arbiter with a behavioural 1-cycle RAM.
// Read expectations are queued at issue and checked by a separate monitor.
module tb_image_ram_arbiter;
   localparam int          AW  = 16;
   localparam int          DW  = 32;
   localparam int unsigned IMG = 32'hFF00;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   image_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   image_ram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(IMG), .RAM_LAT(1)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem     [65536];
   logic [31:0] ref_mem [65536];

   always @(posedge clk) begin
      if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
      bus.ram_q <= mem[bus.ram_address];
   end

   function automatic logic [31:0] pre(input logic [15:0] a);
      return {a ^ 16'h5A5A, a};
   endfunction

   function automatic logic [31:0] exp_rd(input logic [15:0] a);
      return (32'(a) >= IMG) ? 32'h0 : ref_mem[a];
   endfunction

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t disp_q[$];
   exp_t eng_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic g_ld;
   logic g_eng;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per rvalid pulse, flags stale entries.
   always @(negedge clk) begin
      exp_t e;
      if (bus.disp_rvalid) begin
         if (disp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL disp_unexpected: got pulse data %0h expected none",
                     bus.disp_rdata);
         end else begin
            e = disp_q.pop_front();
            chk("disp_rdata", bus.disp_rdata, e.data);
            chk("disp_latency", 32'(cyc), 32'(e.due));
         end
      end
      if (bus.eng_rvalid) begin
         if (eng_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL eng_unexpected: got pulse data %0h expected none",
                     bus.eng_rdata);
         end else begin
            e = eng_q.pop_front();
            chk("eng_rdata", bus.eng_rdata, e.data);
            chk("eng_latency", 32'(cyc), 32'(e.due));
         end
      end
      while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
         e = disp_q.pop_front();
         checks++; errors++;
         $display("FAIL disp_missing: got no pulse expected data %0h at %0d",
                  e.data, e.due);
      end
      while (eng_q.size() > 0 && eng_q[0].due < cyc) begin
         e = eng_q.pop_front();
         checks++; errors++;
         $display("FAIL eng_missing: got no pulse expected data %0h at %0d",
                  e.data, e.due);
      end
   end

   task automatic sample();
      exp_t e;
      g_ld  = bus.ld_gnt;
      g_eng = bus.eng_gnt;
      if (bus.disp_req) begin
         e.data = exp_rd(bus.disp_addr);
         e.due  = cyc + 3;
         disp_q.push_back(e);
      end
      if (g_ld && 32'(bus.ld_addr) < IMG)
         ref_mem[bus.ld_addr] = bus.ld_wdata;
      if (g_eng) begin
         if (bus.eng_we) begin
            if (32'(bus.eng_addr) < IMG)
               ref_mem[bus.eng_addr] = bus.eng_wdata;
         end else begin
            e.data = exp_rd(bus.eng_addr);
            e.due  = cyc + 3;
            eng_q.push_back(e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      int li;
      int ei;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = pre(16'(i));
         ref_mem[i] = pre(16'(i));
      end
      bus.disp_req  = 1'b0;
      bus.disp_addr = '0;
      bus.ld_req    = 1'b1;
      bus.ld_addr   = 16'h0200;
      bus.ld_wdata  = 32'h1111_0000;
      bus.eng_req   = 1'b1;
      bus.eng_we    = 1'b0;
      bus.eng_addr  = 16'h0200;
      bus.eng_wdata = '0;

      #1 reset = 1'b1;
      #2;
      chk("rst_ram_address", 32'(bus.ram_address), 0);
      chk("rst_ram_data", bus.ram_data, 0);
      chk("rst_ram_wren", 32'(bus.ram_wren), 0);
      chk("rst_disp_rvalid", 32'(bus.disp_rvalid), 0);
      chk("rst_eng_rvalid", 32'(bus.eng_rvalid), 0);
      chk("rst_ld_gnt", 32'(bus.ld_gnt), 0);
      chk("rst_eng_gnt", 32'(bus.eng_gnt), 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Tie: loader first, then strict alternation.
      li = 0;
      ei = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("tie_ld_gnt", 32'(g_ld), (i % 2 == 0) ? 1 : 0);
         chk("tie_eng_gnt", 32'(g_eng), (i % 2 == 1) ? 1 : 0);
         if (g_ld) begin
            li++;
            bus.ld_addr  = 16'h0200 + 16'(li);
            bus.ld_wdata = 32'h1111_0000 + 32'(li);
         end
         if (g_eng) begin
            ei++;
            bus.eng_addr = 16'h0200 + 16'(ei);
         end
      end
      bus.ld_req  = 1'b0;
      bus.eng_req = 1'b0;
      chk("tie_ld_count", 32'(li), 3);
      chk("tie_eng_count", 32'(ei), 3);

      // Engine write then read of the same word.
      bus.eng_req   = 1'b1;
      bus.eng_we    = 1'b1;
      bus.eng_addr  = 16'h0101;
      bus.eng_wdata = 32'hDEAD_BEEF;
      step();
      chk("wr_gnt", 32'(g_eng), 1);
      bus.eng_we = 1'b0;
      @(negedge clk);
      chk("wr_wren_on", 32'(bus.ram_wren), 1);
      chk("wr_address", 32'(bus.ram_address), 32'h0101);
      chk("wr_data", bus.ram_data, 32'hDEAD_BEEF);
      sample();
      chk("rd_gnt", 32'(g_eng), 1);
      @(posedge clk);
      #1 bus.eng_req = 1'b0;
      @(negedge clk);
      chk("wr_wren_off", 32'(bus.ram_wren), 0);
      @(posedge clk);
      #1;

      // Display priority over a waiting loader.
      bus.disp_req = 1'b1;
      bus.ld_req   = 1'b1;
      bus.ld_addr  = 16'h0300;
      bus.ld_wdata = 32'h3333_3333;
      for (int i = 0; i < 10; i++) begin
         bus.disp_addr = 16'h0010 + 16'(i);
         step();
         chk("disp_blocks_ld", 32'(g_ld), 0);
      end
      bus.disp_req = 1'b0;
      step();
      chk("ld_after_disp", 32'(g_ld), 1);
      bus.ld_req = 1'b0;

      // Out-of-range boundary reads and an out-of-range write.
      bus.eng_req  = 1'b1;
      bus.eng_we   = 1'b0;
      bus.eng_addr = 16'hFFFF;
      step();
      chk("oor_rd_gnt", 32'(g_eng), 1);
      bus.eng_addr = 16'hFF00;
      step();
      bus.eng_addr = 16'hFEFF;
      step();
      bus.eng_req  = 1'b0;
      bus.ld_req   = 1'b1;
      bus.ld_addr  = 16'hFF80;
      bus.ld_wdata = 32'h7777_7777;
      step();
      chk("oor_wr_gnt", 32'(g_ld), 1);
      bus.ld_req = 1'b0;
      @(negedge clk);
      chk("oor_wren", 32'(bus.ram_wren), 0);
      chk("oor_address", 32'(bus.ram_address), 32'hFF80);
      @(posedge clk);
      #1;
      repeat (3) step();
      chk("oor_mem_kept", mem[16'hFF80], pre(16'hFF80));

      // Reset with a read in flight and a write pending.
      bus.eng_req  = 1'b1;
      bus.eng_addr = 16'h0020;
      step();
      bus.eng_req  = 1'b0;
      bus.ld_req   = 1'b1;
      bus.ld_addr  = 16'h0021;
      bus.ld_wdata = 32'h5555_5555;
      step();
      chk("pre_reset_wren", 32'(bus.ram_wren), 1);
      ref_mem[16'h0021] = pre(16'h0021);
      bus.eng_req = 1'b1;
      reset = 1'b1;
      eng_q.delete();
      #1;
      chk("mid_rst_wren", 32'(bus.ram_wren), 0);
      chk("mid_rst_address", 32'(bus.ram_address), 0);
      chk("mid_rst_data", bus.ram_data, 0);
      chk("mid_rst_disp_rdata", bus.disp_rdata, 0);
      chk("mid_rst_eng_rdata", bus.eng_rdata, 0);
      @(negedge clk);
      chk("mid_rst_ld_gnt", 32'(bus.ld_gnt), 0);
      chk("mid_rst_eng_gnt", 32'(bus.eng_gnt), 0);
      chk("mid_rst_eng_rvalid", 32'(bus.eng_rvalid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_eng_rvalid2", 32'(bus.eng_rvalid), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      bus.ld_addr  = 16'h0400;
      bus.ld_wdata = 32'h4444_4444;
      bus.eng_addr = 16'h0400;
      step();
      chk("post_rst_tie_ld", 32'(g_ld), 1);
      chk("post_rst_tie_eng", 32'(g_eng), 0);
      bus.ld_req  = 1'b0;
      bus.eng_req = 1'b0;
      step();

      // Full-throughput display sweep.
      bus.disp_req = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.disp_addr = 16'(i);
         step();
      end
      bus.disp_req = 1'b0;
      repeat (5) step();

      if (disp_q.size() != 0 || eng_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: got %0d pending expected 0",
                  disp_q.size() + eng_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/image_ram_arbiter.md
# image_ram_arbiter

Shares the single-port 32-bit image RAM (65536 words, 256x256 pixels) between three requesters: the VGA display reader, the image loader (write-only), and the processing engine (read/write). The display reader has absolute priority so pixels are never late. The loader and engine share the remaining cycles round-robin. The block sits between the VGA painting logic, the loader, the engine and the `ram` instance, and it owns the RAM's address, data and wren pins.

## Interface
- `ADDR_W`, 16, RAM word address width.
- `DATA_W`, 32, RAM word width.
- `IMG_WORDS`, 65536, number of valid words; addresses at or above this are out of range.
- `RAM_LAT`, 1, cycles from a `ram_address` register update until `ram_q` is valid for capture.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high; clears all state.
- `disp_req` in 1: display read request; no handshake, always served.
- `disp_addr` in ADDR_W: display read address.
- `disp_rdata` out DATA_W: display read data.
- `disp_rvalid` out 1: `disp_rdata` is valid this cycle.
- `ld_req` in 1: loader write request (valid).
- `ld_addr` in ADDR_W: loader write address.
- `ld_wdata` in DATA_W: loader write data.
- `ld_gnt` out 1: loader ready. Combinational. A transfer happens on an edge where `ld_req & ld_gnt`.
- `eng_req` in 1: engine request (valid).
- `eng_we` in 1: engine write when 1, read when 0.
- `eng_addr` in ADDR_W: engine address.
- `eng_wdata` in DATA_W: engine write data.
- `eng_gnt` out 1: engine ready. Combinational, same transfer rule as `ld_gnt`.
- `eng_rdata` out DATA_W: engine read data.
- `eng_rvalid` out 1: `eng_rdata` is valid this cycle.
- `ram_address` out ADDR_W: registered RAM address.
- `ram_data` out DATA_W: registered RAM write data.
- `ram_wren` out 1: registered RAM write enable.
- `ram_q` in DATA_W: RAM read data.

## Operation
- One RAM command per cycle. Winner selection each cycle:
  - `disp_req`=1: display wins; `ld_gnt`=`eng_gnt`=0.
  - Else, only one of loader/engine requesting: that one wins.
  - Else, both requesting: the requester that did not win last wins. The `rr_last` pointer updates only on a loader/engine transfer.
- A requester must hold its req and payload stable until its gnt is seen high. gnt never asserts without req.
- On the edge of a transfer, the winner's address, data and we are registered onto `ram_*`. Display and engine reads set `ram_wren`=0.
- No request on the edge: `ram_wren`<=0. `ram_address` and `ram_data` hold their previous values.
- Out-of-range address (>= IMG_WORDS):
  - The transfer is still accepted (gnt asserts normally).
  - `ram_wren` is forced 0.
  - A read returns data 0 with rvalid asserted normally.
- Read tag pipeline:
  - Depth RAM_LAT+1; each entry is {valid, owner (DISP/ENG), oor}.
  - Shifts every cycle.
  - At the output stage, `ram_q` (or 0 if oor) is registered into the owner's rdata, and that owner's rvalid is pulsed for 1 cycle.
- Read data is returned in request order per owner. Display and engine returns never collide, since at most one read issues per cycle.
- Write followed by a read of the same address on the next accepted command returns the new data; commands are strictly serialized.

## Timing
- Reset values:
  - `ram_address`=0, `ram_data`=0, `ram_wren`=0.
  - `disp_rdata`=0, `eng_rdata`=0, `disp_rvalid`=0, `eng_rvalid`=0.
  - Tag pipeline all invalid; `rr_last`=ENG, so the loader wins the first tie.
  - `ld_gnt`=`eng_gnt`=0 while `reset`=1.
- Read latency:
  - A read accepted at edge k drives the `ram_*` registers after k.
  - The RAM captures them at k+1 (RAM_LAT=1).
  - rdata and rvalid are high in the cycle after edge k+1+RAM_LAT, i.e. after edge k+2 by default.
  - This gives 1 result per cycle at full throughput.
- Write: `ram_wren`=1 for exactly one cycle, starting after the accepting edge.
- Reset mid-operation: in-flight reads are discarded with no rvalid pulse, and a pending `ram_wren` clears immediately (asynchronously).
- Starvation: the loader and engine may wait indefinitely while `disp_req` is continuously high. Between themselves, each waits at most 1 transfer when both are requesting.

## Test plan
- Engine write 0xDEADBEEF to 0x0101, then engine read of 0x0101 -> `ram_wren` pulse of 1 cycle with `ram_address`=0x0101; `eng_rvalid` 2 cycles after the read is accepted with `eng_rdata`=0xDEADBEEF.
- `ld_req` and `eng_req` held high for 6 cycles, `disp_req`=0 -> grants alternate L,E,L,E,L,E; each requester gets 3 transfers.
- `disp_req` high for 10 cycles with `ld_req` high -> `ld_gnt`=0 throughout; 10 `disp_rvalid` pulses in address order. `ld_gnt` asserts in the first cycle after `disp_req` falls.
- Engine read of 0xFFFF with IMG_WORDS=0xFF00 -> accepted; `eng_rvalid` arrives on time with `eng_rdata`=0. An out-of-range loader write leaves `ram_wren`=0.
- Assert `reset` one cycle after an engine read is accepted -> no `eng_rvalid`; all outputs return to 0 asynchronously. The first post-reset tie grants the loader.
- Back-to-back display reads of 0x0000..0x00FF -> `disp_rvalid` high for 256 consecutive cycles; data matches RAM preload order.
